// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one block-oriented data memory port
// among N_REQ data caches. Each grant runs IDLE -> BUSY -> DONE. The
// released requester sees its busywait drop for the single DONE cycle.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no operation in flight; the next edge grants the first active
//       | requester found scanning from ptr
// BUSY  | memory strobe held for requester g; waits for mem_busywait low
//       | after at least one full cycle in BUSY
// DONE  | one-cycle release of requester g; ptr advances to g+1 on exit
module mem_bus_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_read,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_address,
    input  logic [N_REQ*DATA_W-1:0]   req_writedata,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [N_REQ-1:0]          req_busywait,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_writedata,
    input  logic [DATA_W-1:0]         mem_readdata,
    input  logic                      mem_busywait
);

    // g and ptr are 2 bits wide, so the pointer arithmetic below wraps
    // modulo 4, which matches the four requesters.
    localparam int G_W = 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [G_W-1:0]    g;
    logic [G_W-1:0]    ptr;
    logic              busy_seen;

    logic [N_REQ-1:0]  active;
    logic              any_active;
    logic [G_W-1:0]    next_g;
    logic [G_W-1:0]    scan_idx;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_read;
    logic              sel_write;
    logic              done_now;

    assign active = req_read | req_write;

    // While reset is held the arbiter is treated as IDLE, so nobody is released.
    assign done_now = (state == DONE) & ~reset;

    // Round-robin scan: walk offsets from the highest to the lowest so that
    // the active requester closest to ptr is the last one written and wins.
    always_comb begin
        next_g     = ptr;
        any_active = 1'b0;
        scan_idx   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = ptr + G_W'(k);
            if (active[scan_idx]) begin
                next_g     = scan_idx;
                any_active = 1'b1;
            end
        end
    end

    // Pick the winning requester's address, data and operation. If both
    // read and write are asserted, the write takes priority.
    always_comb begin
        sel_address   = '0;
        sel_writedata = '0;
        sel_read      = 1'b0;
        sel_write     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (next_g == G_W'(i)) begin
                sel_address   = req_address[i*ADDR_W +: ADDR_W];
                sel_writedata = req_writedata[i*DATA_W +: DATA_W];
                sel_write     = req_write[i];
                sel_read      = req_read[i] & ~req_write[i];
            end
        end
    end

    // Stall every active requester except the one being released this cycle.
    always_comb begin
        req_busywait = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_busywait[i] = active[i] & ~(done_now & (g == G_W'(i)));
        end
    end

    // Arbitration FSM with registered memory-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            g             <= '0;
            ptr           <= '0;
            busy_seen     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            req_readdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_active) begin
                        state         <= BUSY;
                        g             <= next_g;
                        busy_seen     <= 1'b0;
                        mem_address   <= sel_address;
                        mem_writedata <= sel_writedata;
                        mem_write     <= sel_write;
                        mem_read      <= sel_read;
                    end
                end
                BUSY: begin
                    // The first BUSY edge never completes, even when memory
                    // is already idle, so BUSY always lasts at least 2 cycles.
                    if (!busy_seen) begin
                        busy_seen <= 1'b1;
                    end else if (!mem_busywait) begin
                        state     <= DONE;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        if (mem_read) begin
                            req_readdata <= mem_readdata;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ptr   <= g + G_W'(1);
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_bus_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic                    clock;
    logic                    reset;
    logic [N_REQ-1:0]        req_read;
    logic [N_REQ-1:0]        req_write;
    logic [N_REQ*ADDR_W-1:0] req_address;
    logic [N_REQ*DATA_W-1:0] req_writedata;
    logic [DATA_W-1:0]       req_readdata;
    logic [N_REQ-1:0]        req_busywait;
    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-1:0]       mem_address;
    logic [DATA_W-1:0]       mem_writedata;
    logic [DATA_W-1:0]       mem_readdata;
    logic                    mem_busywait;

    mem_bus_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_address   (req_address),
        .req_writedata (req_writedata),
        .req_readdata  (req_readdata),
        .req_busywait  (req_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: owner of the bus (-1 if none), whether
    // the owner is in its release cycle, and the memory operation in flight.
    int                m_owner = -1;
    bit                m_release = 1'b0;
    int                m_busy_cycles = 0;
    int                m_ptr = 0;
    logic              m_rd = 1'b0;
    logic              m_wr = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_rdata = '0;

    // Memory responder state
    bit                rand_mode = 1'b0;
    int                mem_delay = 0;
    int                mem_cnt = 0;
    bit                mem_active = 1'b0;
    logic [DATA_W-1:0] rd_block = '0;

    // Observations of the DUT
    int                grant_log[$];
    bit                prev_strobe = 1'b0;
    int                dut_rel[N_REQ];
    logic [N_REQ-1:0]  last_bw;

    function automatic bit is_active(input int i);
        return req_read[i] | req_write[i];
    endfunction

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_edge();
        if (reset) begin
            m_owner = -1; m_release = 1'b0; m_ptr = 0;
            m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_release) begin
            m_release = 1'b0;
            m_ptr = (m_owner + 1) % N_REQ;
            m_owner = -1;
        end else if (m_owner >= 0) begin
            if (m_busy_cycles >= 1 && !mem_busywait) begin
                m_release = 1'b1;
                if (m_rd) m_rdata = mem_readdata;
                m_rd = 1'b0;
                m_wr = 1'b0;
            end else begin
                m_busy_cycles++;
            end
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                int i;
                i = (m_ptr + k) % N_REQ;
                if (m_owner < 0 && is_active(i)) m_owner = i;
            end
            if (m_owner >= 0) begin
                m_busy_cycles = 0;
                m_wr    = req_write[m_owner];
                m_rd    = req_read[m_owner] & ~req_write[m_owner];
                m_addr  = req_address[m_owner*ADDR_W +: ADDR_W];
                m_wdata = req_writedata[m_owner*DATA_W +: DATA_W];
            end
        end
    endtask

    task automatic check_outputs();
        logic [N_REQ-1:0] exp_bw;
        for (int i = 0; i < N_REQ; i++)
            exp_bw[i] = is_active(i) && !(m_release && m_owner == i && !reset);
        check_eq("mem_read", mem_read, m_rd);
        check_eq("mem_write", mem_write, m_wr);
        check_eq("mem_address", mem_address, m_addr);
        check_eq("mem_writedata", mem_writedata, m_wdata);
        check_eq("req_readdata", req_readdata, m_rdata);
        check_eq("req_busywait", req_busywait, exp_bw);
    endtask

    task automatic observe();
        bit strobe;
        int id;
        last_bw = req_busywait;
        for (int i = 0; i < N_REQ; i++)
            if (is_active(i) && !req_busywait[i]) dut_rel[i]++;
        strobe = mem_read | mem_write;
        if (strobe && !prev_strobe && !rand_mode) begin
            id = -1;
            for (int i = N_REQ - 1; i >= 0; i--)
                if (mem_address == req_address[i*ADDR_W +: ADDR_W]) id = i;
            grant_log.push_back(id);
        end
        prev_strobe = strobe;
    endtask

    task automatic drive_mem();
        if (mem_read | mem_write) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_cnt = rand_mode ? $urandom_range(0, 3) : mem_delay;
                if (rand_mode) rd_block = {$urandom, $urandom, $urandom, $urandom};
                mem_readdata = rd_block;
            end
            mem_busywait = (mem_cnt > 0);
            if (mem_cnt > 0) mem_cnt--;
        end else begin
            mem_active = 1'b0;
            mem_busywait = rand_mode ? 1'($urandom % 2) : 1'b0;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
        observe();
        drive_mem();
    endtask

    // Requester released this cycle drops its request.
    task automatic auto_drop();
        for (int i = 0; i < N_REQ; i++)
            if (m_release && m_owner == i && !reset) begin
                req_read[i] = 1'b0;
                req_write[i] = 1'b0;
            end
    endtask

    task automatic step();
        tick();
        auto_drop();
    endtask

    task automatic run_drain(input int max_cycles);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < max_cycles) begin
            step();
            n++;
            done = ((req_read | req_write) == '0) && (m_owner < 0);
        end
        check_eq("drain_done", done, 1'b1);
    endtask

    task automatic clear_obs();
        grant_log.delete();
        for (int i = 0; i < N_REQ; i++) dut_rel[i] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_read = '0;
        req_write = '0;
        req_address = '0;
        req_writedata = '0;
        mem_readdata = '0;
        mem_busywait = 1'b0;
        req_address[0*ADDR_W +: ADDR_W] = 28'h0001000;
        req_address[1*ADDR_W +: ADDR_W] = 28'h0002000;
        req_address[2*ADDR_W +: ADDR_W] = 28'h0000ABC;
        req_address[3*ADDR_W +: ADDR_W] = 28'h0004000;
        for (int i = 0; i < N_REQ; i++)
            req_writedata[i*DATA_W +: DATA_W] = {4{32'hA0000000 + 32'(i)}};

        // Reset state
        do_reset();
        check_eq("rst_mem_read", mem_read, 1'b0);
        check_eq("rst_readdata", req_readdata, '0);

        // Single read by requester 2, memory busy 5 cycles
        clear_obs();
        mem_delay = 5;
        rd_block = {4{32'hDEADBEEF}};
        req_read = 4'b0100;
        step();
        check_eq("s1_mem_read", mem_read, 1'b1);
        check_eq("s1_mem_write", mem_write, 1'b0);
        check_eq("s1_mem_address", mem_address, 28'h0000ABC);
        run_drain(30);
        check_eq("s1_release_once", dut_rel[2], 1);
        check_eq("s1_readdata", req_readdata, {4{32'hDEADBEEF}});
        // ptr now 3: requester 3 beats requester 0
        clear_obs();
        req_read = 4'b1001;
        run_drain(40);
        check_eq("s1_ngrants", grant_log.size(), 2);
        check_eq("s1_ptr_grant0", grant_log[0], 3);
        check_eq("s1_ptr_grant1", grant_log[1], 0);

        // All four read together from reset
        do_reset();
        clear_obs();
        mem_delay = 1;
        rd_block = {4{32'hCAFEF00D}};
        req_read = 4'b1111;
        run_drain(80);
        check_eq("s2_ngrants", grant_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check_eq("s2_grant_order", grant_log[k], k);
            check_eq("s2_release_once", dut_rel[k], 1);
        end

        // Write wins over read for requester 1; read data untouched
        rd_block = {4{32'h55AA55AA}};
        req_writedata[1*DATA_W +: DATA_W] = {4{32'h12345678}};
        req_read = 4'b0010;
        req_write = 4'b0010;
        step();
        check_eq("s3_mem_write", mem_write, 1'b1);
        check_eq("s3_mem_read", mem_read, 1'b0);
        check_eq("s3_writedata", mem_writedata, {4{32'h12345678}});
        run_drain(30);
        check_eq("s3_readdata_kept", req_readdata, {4{32'hCAFEF00D}});

        // Memory idle on the first BUSY cycle: still two BUSY cycles
        mem_delay = 0;
        req_read = 4'b0001;
        step();
        step();
        check_eq("s4_bw_busy2", last_bw[0], 1'b1);
        step();
        check_eq("s4_bw_done", last_bw[0], 1'b0);
        run_drain(10);

        // Reset in the 2nd BUSY cycle of a grant to requester 3
        do_reset();
        mem_delay = 5;
        req_read = 4'b1000;
        step();
        step();
        reset = 1'b1;
        req_read = 4'b1110;
        step();
        check_eq("s5_mem_read", mem_read, 1'b0);
        reset = 1'b0;
        clear_obs();
        run_drain(60);
        check_eq("s5_ngrants", grant_log.size(), 3);
        check_eq("s5_first_grant", grant_log[0], 1);

        // Requester 0 withdraws mid-BUSY while requester 2 waits
        do_reset();
        clear_obs();
        mem_delay = 4;
        req_read = 4'b0101;
        step();
        step();
        req_read[0] = 1'b0;
        run_drain(40);
        check_eq("s6_ngrants", grant_log.size(), 2);
        check_eq("s6_grant0", grant_log[0], 0);
        check_eq("s6_grant1", grant_log[1], 2);
        check_eq("s6_release2", dut_rel[2], 1);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom % 400 == 0);
            for (int i = 0; i < N_REQ; i++) begin
                if (!is_active(i)) begin
                    if ($urandom % 4 == 0) begin
                        case ($urandom % 3)
                            0: begin req_read[i] = 1'b1; req_write[i] = 1'b0; end
                            1: begin req_read[i] = 1'b0; req_write[i] = 1'b1; end
                            default: begin req_read[i] = 1'b1; req_write[i] = 1'b1; end
                        endcase
                        req_address[i*ADDR_W +: ADDR_W] = 28'($urandom);
                        req_writedata[i*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
                    end
                end else if ($urandom % 64 == 0) begin
                    req_read[i] = 1'b0;
                    req_write[i] = 1'b0;
                end
            end
            step();
        end
        reset = 1'b0;
        rand_mode = 1'b0;
        run_drain(100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, 4, number of dcache requesters; ADDR_W, 28, block address width; DATA_W, 128, block data width.
REQ-002 Port `clock` SHALL be an input, 1 bit wide: the single clock; all state changes occur on its rising edge.
REQ-003 Port `reset` SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 Port `req_read` SHALL be an input, N_REQ bits wide: per-dcache block-read request, held until its busywait drops.
REQ-005 Port `req_write` SHALL be an input, N_REQ bits wide: per-dcache block-writeback request, held until its busywait drops.
REQ-006 Port `req_address` SHALL be an input, N_REQ*ADDR_W bits wide: packed block addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-007 Port `req_writedata` SHALL be an input, N_REQ*DATA_W bits wide: packed write blocks, requester i at bits [i*DATA_W +: DATA_W].
REQ-008 Port `req_readdata` SHALL be an output, DATA_W bits wide: shared read-block return bus.
REQ-009 Port `req_busywait` SHALL be an output, N_REQ bits wide: per-dcache stall.
REQ-010 Port `mem_read` SHALL be an output, 1 bit wide: read strobe to the data memory.
REQ-011 Port `mem_write` SHALL be an output, 1 bit wide: write strobe to the data memory.
REQ-012 Port `mem_address` SHALL be an output, ADDR_W bits wide: block address to the data memory.
REQ-013 Port `mem_writedata` SHALL be an output, DATA_W bits wide: write block to the data memory.
REQ-014 Port `mem_readdata` SHALL be an input, DATA_W bits wide: read block from the data memory.
REQ-015 Port `mem_busywait` SHALL be an input, 1 bit wide: data memory busy.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, BUSY and DONE; a 2-bit grant register `g` and a 2-bit round-robin pointer `ptr` SHALL be kept.
REQ-017 Requester i is active when req_read[i] | req_write[i] is 1.
REQ-018 In IDLE with at least one active requester, the next edge SHALL set g to the first active index found scanning ptr, ptr+1, ... modulo 4, and SHALL enter BUSY.
REQ-019 On IDLE->BUSY, the arbiter SHALL register mem_address and mem_writedata from requester g; mem_write SHALL become req_write[g], and mem_read SHALL become req_read[g] & ~req_write[g] (write wins if both are asserted).
REQ-020 In BUSY, the mem_* outputs SHALL hold constant; a transition to DONE SHALL occur on the first edge where mem_busywait==0 and the arbiter has already spent at least 1 full cycle in BUSY (minimum BUSY length 2 cycles).
REQ-021 On BUSY->DONE, the arbiter SHALL deassert mem_read and mem_write, and SHALL latch mem_readdata into req_readdata when the operation was a read; after a write, req_readdata SHALL keep its previous value.
REQ-022 DONE SHALL last exactly 1 cycle, then go to IDLE with ptr set to (g+1) mod 4.
REQ-023 req_busywait[i] SHALL be combinational: active(i) & ~(state==DONE & g==i); inactive requesters always see 0.
REQ-024 Requests arriving or changing while in BUSY or DONE SHALL NOT affect g or the mem_* outputs until the next IDLE arbitration.
REQ-025 If requester g withdraws its request during BUSY, the memory operation SHALL still complete and the DONE cycle SHALL still occur.
REQ-026 Latency SHALL be: request seen in IDLE at edge N gives mem strobe at N+1, and busywait low in the cycle after the mem_busywait-low edge; the best case from request to release is 3 cycles.
REQ-027 Starvation bound: any held request SHALL be granted within 4 arbitrations.

Reset
REQ-028 When reset is high at a rising edge, the arbiter SHALL set state=IDLE, g=0, ptr=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0 and req_readdata=0.
REQ-029 Reset SHALL take priority over all transitions, including in mid-BUSY (the memory operation is abandoned).
REQ-030 While reset is active, req_busywait SHALL still follow REQ-023 with state=IDLE.

Verification
REQ-031 The bench SHALL cover: reset, then only req_read[2]=1 with address 0x0000ABC, memory busy 5 cycles returning 0xDEADBEEF...; required response: mem_read=1 with mem_address=0x0000ABC one cycle later, busywait[2]=0 for exactly 1 cycle, req_readdata equal to the returned block, ptr=3.
REQ-032 The bench SHALL cover all four requesters reading simultaneously from reset; required response: grants in order 0,1,2,3, each requester released exactly once, and no overlapping mem strobes.
REQ-033 The bench SHALL cover req_write[1] with writedata 0x1234... while req_read[1] is also 1; required response: only mem_write=1, and req_readdata unchanged after DONE.
REQ-034 The bench SHALL cover reset asserted in the 2nd BUSY cycle of a grant to requester 3; required response: mem_read=0 on the next edge, state IDLE, ptr=0, and the next arbitration grants the lowest active index.
REQ-035 The bench SHALL cover memory with mem_busywait already 0 on the first BUSY cycle; required response: BUSY still lasts 2 cycles before DONE.
REQ-036 The bench SHALL cover requester 0 dropping its request mid-BUSY while requester 2 is waiting; required response: the grant to 0 completes, and requester 2 is granted next.
